// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the iterative ALU and the ALU controller:
//   - 4-bit operation codes driven on the Operation bus
//   - FSM state encoding of alu_iter
//   - single-step shifter mode encoding
//   - small helpers that classify an operation code
// ---------------------------------------------------------------------------
package alu_pkg;

    // Operation codes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_BGE = 4'b0101;
    localparam logic [3:0] OP_BNE = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1100;
    localparam logic [3:0] OP_BLT = 4'b1101;
    localparam logic [3:0] OP_SLT = 4'b1110;

    // Iterative ALU control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // One-bit shifter modes
    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_e;

    // True for the three operations that run through the iterative shifter.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Map a shift opcode onto the shifter mode; non-shift codes never reach
    // the shifter, so their mapping is irrelevant.
    function automatic shift_mode_e shift_mode(input logic [3:0] op);
        shift_mode_e m;
        case (op)
            OP_SRL:  m = SH_SRL;
            OP_SRA:  m = SH_SRA;
            default: m = SH_SLL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_shift1.sv
// ---------------------------------------------------------------------------
// alu_shift1
// Combinational single-position shifter used by the iterative ALU.
// Ports:
//   value_i  DATA_W-bit value to shift
//   mode_i   SH_SLL (zero-fill left), SH_SRL (zero-fill right),
//            SH_SRA (sign-fill right)
//   value_o  value_i shifted by exactly one bit position
// ---------------------------------------------------------------------------
module alu_shift1
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] value_i,
    input  shift_mode_e       mode_i,
    output logic [DATA_W-1:0] value_o
);

    always_comb begin
        value_o = value_i;
        case (mode_i)
            SH_SLL:  value_o = {value_i[DATA_W-2:0], 1'b0};
            SH_SRL:  value_o = {1'b0, value_i[DATA_W-1:1]};
            SH_SRA:  value_o = {value_i[DATA_W-1], value_i[DATA_W-1:1]};
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// alu_iter
// Iterative ALU with a valid/ready handshake on both sides. Single-cycle
// operations complete on the accepting edge; SLL/SRL/SRA move one bit per
// clock through alu_shift1, so a shift by n takes 1+n cycles.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   flush      synchronous abort of any in-flight operation (highest priority)
//   in_valid   request present          in_ready   accepting (IDLE only)
//   Operation  4-bit opcode (alu_pkg)   SrcA/SrcB  DATA_W-bit operands
//   out_valid  result present (DONE)    out_ready  consumer takes result
//   ALUResult  registered result        Zero       registered ALUResult==0
// ---------------------------------------------------------------------------
module alu_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero
);

    state_e             state_q,  state_d;
    logic [DATA_W-1:0]  acc_q,    acc_d;
    logic [4:0]         cnt_q,    cnt_d;
    shift_mode_e        mode_q,   mode_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q,   zero_d;

    logic [DATA_W-1:0]  comb_result;
    logic [DATA_W-1:0]  shifted;
    logic [4:0]         shamt;
    logic               signed_lt;

    assign shamt     = SrcB[4:0];
    assign signed_lt = $signed(SrcA) < $signed(SrcB);

    // Result of every operation that finishes on the accepting edge. For the
    // shift codes this path is only used when shamt is zero, i.e. SrcA.
    always_comb begin
        comb_result = '0;
        case (Operation)
            OP_AND:  comb_result = SrcA & SrcB;
            OP_XOR:  comb_result = SrcA ^ SrcB;
            OP_SUB:  comb_result = SrcA - SrcB;
            OP_OR:   comb_result = SrcA | SrcB;
            OP_ADD:  comb_result = SrcA + SrcB;
            OP_BGE:  comb_result = {{(DATA_W-1){1'b0}}, ~signed_lt};
            OP_BNE:  comb_result = {{(DATA_W-1){1'b0}}, SrcA != SrcB};
            OP_BEQ:  comb_result = {{(DATA_W-1){1'b0}}, SrcA == SrcB};
            OP_BLT:  comb_result = {{(DATA_W-1){1'b0}}, signed_lt};
            OP_SLT:  comb_result = {{(DATA_W-1){1'b0}}, signed_lt};
            OP_LUI:  comb_result = SrcB;
            OP_SLL:  comb_result = SrcA;
            OP_SRL:  comb_result = SrcA;
            OP_SRA:  comb_result = SrcA;
            default: comb_result = '0;
        endcase
    end

    alu_shift1 #(
        .DATA_W (DATA_W)
    ) u_shift1 (
        .value_i (acc_q),
        .mode_i  (mode_q),
        .value_o (shifted)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush && in_valid) begin
                    if (is_shift(Operation) && (shamt != 5'd0)) begin
                        state_d = ST_SHIFT;
                        acc_d   = SrcA;
                        cnt_d   = shamt;
                        mode_d  = shift_mode(Operation);
                    end else begin
                        state_d  = ST_DONE;
                        result_d = comb_result;
                        zero_d   = (comb_result == '0);
                    end
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = shifted;
                    cnt_d = cnt_q - 5'd1;
                    // Last step: publish the shifted value on the same edge
                    // so the result is visible as soon as DONE is entered.
                    if (cnt_q == 5'd1) begin
                        state_d  = ST_DONE;
                        result_d = shifted;
                        zero_d   = (shifted == '0);
                    end
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= SH_SLL;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// ---------------------------------------------------------------------------
// tb_alu_iter
// Self-checking bench for alu_iter: a table of directed vectors, hand-written
// flush/reset/backpressure sequences, and random operations compared against
// an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    alu_iter #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    // Reference model: plain arithmetic straight from the operation table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        logic [4:0] sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (op)
            4'd0:  return a & b;
            4'd1:  return a ^ b;
            4'd2:  return a - b;
            4'd3:  return a | b;
            4'd4:  return a + b;
            4'd5:  return (sa >= sb) ? 32'd1 : 32'd0;
            4'd6:  return (a != b) ? 32'd1 : 32'd0;
            4'd7:  return 32'(sa >>> sh);
            4'd8:  return (a == b) ? 32'd1 : 32'd0;
            4'd9:  return a << sh;
            4'd10: return b;
            4'd12: return a >> sh;
            4'd13: return (sa < sb) ? 32'd1 : 32'd0;
            4'd14: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if ((op == 4'd7 || op == 4'd9 || op == 4'd12) && sh != 5'd0) return 1 + int'(sh);
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction. lat counts edges from the accepting edge (1) up to
    // the edge after which out_valid is seen. busy_ok: in_ready stayed low
    // while waiting. hold_ok: result/out_valid stable during the delay.
    // idle_ok: back in IDLE one edge after out_ready, with no new accept even
    // if push_on_release kept in_valid high on that edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int delay, input bit push_on_release,
                          output logic [31:0] res, output logic zero, output int lat,
                          output bit busy_ok, output bit hold_ok, output bit idle_ok);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!out_valid && lat <= 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        res = ALUResult; zero = Zero;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            if (ALUResult !== res || Zero !== zero || out_valid !== 1'b1 || in_ready !== 1'b0)
                hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        if (push_on_release) begin
            Operation = 4'd4; SrcA = 32'd7; SrcB = 32'd8; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        idle_ok = in_ready && !out_valid;
        in_valid = 1'b0;
    endtask

    logic [31:0] r;
    logic        z;
    int          lat;
    bit          busy_ok, hold_ok, idle_ok;
    bit          seen_valid;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{4'b0100, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1};
        vecs[1]  = '{4'b0111, 32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 5};
        vecs[2]  = '{4'b1110, 32'hFFFF_FFFE, 32'h1,         32'h1,         1'b0, 1};
        vecs[3]  = '{4'b0101, 32'hFFFF_FFFE, 32'h1,         32'h0,         1'b1, 1};
        vecs[4]  = '{4'b0010, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1};
        vecs[5]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
        vecs[6]  = '{4'b0011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1};
        vecs[7]  = '{4'b0001, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1};
        vecs[8]  = '{4'b1000, 32'h1234,      32'h1234,      32'h1,         1'b0, 1};
        vecs[9]  = '{4'b0110, 32'h1234,      32'h1234,      32'h0,         1'b1, 1};
        vecs[10] = '{4'b1101, 32'h1,         32'hFFFF_FFFE, 32'h0,         1'b1, 1};
        vecs[11] = '{4'b1010, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1};
        vecs[12] = '{4'b1100, 32'h8000_0000, 32'h20,        32'h8000_0000, 1'b0, 1};
        vecs[13] = '{4'b1001, 32'h3,         32'h4,         32'h30,        1'b0, 5};
        vecs[14] = '{4'b1011, 32'h5,         32'h6,         32'h0,         1'b1, 1};
        vecs[15] = '{4'b0111, 32'h7FFF_FFFF, 32'h1F,        32'h0,         1'b1, 32};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Operation = 4'd0; SrcA = '0; SrcB = '0;
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset ALUResult", ALUResult, 0);
        check("reset Zero", Zero, 1);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, r, z, lat, busy_ok, hold_ok, idle_ok);
            check($sformatf("vec%0d op%0d result", i, vecs[i].op), r, vecs[i].res);
            check($sformatf("vec%0d op%0d zero", i, vecs[i].op), z, vecs[i].zero);
            check($sformatf("vec%0d op%0d latency", i, vecs[i].op), lat, vecs[i].lat);
            check($sformatf("vec%0d in_ready low while busy", i), busy_ok, 1);
            check($sformatf("vec%0d back to idle", i), idle_ok, 1);
            $display("vec %0d: op=%b a=%08h b=%08h -> res=%08h zero=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
        end

        // Backpressure: SLL 1<<31 held for 10 cycles, then release with
        // in_valid high on the release edge (must not be accepted).
        run_op(4'b1001, 32'h1, 32'd31, 10, 1'b1, r, z, lat, busy_ok, hold_ok, idle_ok);
        check("bp result", r, 32'h8000_0000);
        check("bp latency", lat, 32);
        check("bp held stable", hold_ok, 1);
        check("bp idle after release, no accept", idle_ok, 1);
        $display("backpressure: res=%08h lat=%0d hold=%0d idle=%0d", r, lat, hold_ok, idle_ok);

        // Flush beats in_valid in IDLE
        flush = 1'b1; in_valid = 1'b1; Operation = 4'd4; SrcA = 32'd1; SrcB = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush blocks accept", in_ready, 1);

        // Flush on the 3rd SHIFT cycle of SRL by 20
        Operation = 4'b1100; SrcA = 32'hF000_0000; SrcB = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush -> idle", in_ready, 1);
        seen_valid = out_valid;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("flush no out_valid", seen_valid, 0);
        run_op(4'b0100, 32'd2, 32'd3, 0, 1'b0, r, z, lat, busy_ok, hold_ok, idle_ok);
        check("post-flush ADD result", r, 32'd5);
        check("post-flush ADD latency", lat, 1);
        $display("flush sequence: next ADD res=%0d lat=%0d", r, lat);

        // Reset asserted mid-SHIFT (ALUResult currently 5)
        Operation = 4'b1100; SrcA = 32'hF000_0000; SrcB = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #1 reset = 1'b1;
        #1;
        check("async reset in_ready", in_ready, 1);
        check("async reset out_valid", out_valid, 0);
        check("async reset ALUResult", ALUResult, 0);
        check("async reset Zero", Zero, 1);
        @(negedge clk); reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("reset mid-shift no output", seen_valid, 0);

        // Reset while in DONE
        Operation = 4'b0100; SrcA = 32'd2; SrcB = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre-reset DONE out_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("reset in DONE out_valid", out_valid, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("after reset in DONE idle", in_ready, 1);

        run_op(4'b1111, 32'h5, 32'h6, 0, 1'b0, r, z, lat, busy_ok, hold_ok, idle_ok);
        check("op1111 result", r, 32'd0);
        check("op1111 zero", z, 1);
        $display("reset sequence: op1111 res=%08h zero=%0d", r, z);

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op(rop, ra, rb, $urandom_range(0, 3), 1'b0, r, z, lat, busy_ok, hold_ok, idle_ok);
            check($sformatf("rand%0d op%0d result", i, rop), r, ref_alu(rop, ra, rb));
            check($sformatf("rand%0d op%0d zero", i, rop), z, (ref_alu(rop, ra, rb) == 32'd0));
            check($sformatf("rand%0d op%0d latency", i, rop), lat, ref_lat(rop, rb));
            check($sformatf("rand%0d hold", i), hold_ok, 1);
            $display("rand %0d: op=%b a=%08h b=%08h -> res=%08h zero=%0d lat=%0d",
                     i, rop, ra, rb, r, z, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, which sets the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous abort of any in-flight operation.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port Operation, input, 4 bits: the ALU operation code from the ALU controller.
REQ-008 The block SHALL have ports SrcA and SrcB, input, DATA_W bits each: the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: ALUResult and Zero are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port ALUResult, output, DATA_W bits: the registered result.
REQ-012 The block SHALL have port Zero, output, 1 bit: registered flag, high when ALUResult equals 0.

Function
REQ-013 The block SHALL implement the operation encoding AND=0000, XOR=0001, SUB=0010, OR=0011, ADD=0100, BGE=0101, BNE=0110, SRA=0111, BEQ=1000, SLL=1001, LUI=1010, SRL=1100, BLT=1101, SLT=1110.
REQ-014 ADD, SUB, AND, OR and XOR SHALL give the DATA_W-bit result; carries wrap modulo 2^DATA_W; LUI SHALL give SrcB.
REQ-015 SLT and BLT SHALL give 1 when SrcA < SrcB (signed), else 0; BGE SHALL give 1 when SrcA >= SrcB (signed); BEQ and BNE SHALL give 1 when the equality condition holds, else 0.
REQ-016 Undefined codes (1011, 1111) SHALL give ALUResult = 0.
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 A request SHALL be accepted on a rising edge with in_valid=1 in IDLE; the block SHALL capture Operation, SrcA and SrcB.
REQ-019 Non-shift operations, and shifts with SrcB[4:0]=0, SHALL go IDLE->DONE with the result registered at that edge (latency 1 cycle).
REQ-020 SLL/SRL/SRA with shamt=SrcB[4:0]>0 SHALL go IDLE->SHIFT, loading accumulator=SrcA and counter=shamt.
REQ-021 In SHIFT, each edge SHALL shift the accumulator one bit (SLL zero-fill left, SRL zero-fill right, SRA sign-fill right) and decrement the counter.
REQ-022 The FSM SHALL move SHIFT->DONE on the edge where the counter goes 1->0; total latency SHALL be 1+shamt cycles after acceptance.
REQ-023 DONE SHALL hold ALUResult and Zero stable until out_ready=1, then go DONE->IDLE on that edge; no new request is accepted on that same edge.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state, discarding the result; flush SHALL take priority over in_valid and out_ready.
REQ-025 Zero SHALL be computed from the final result and registered together with it.

Reset
REQ-026 Reset SHALL force state=IDLE, ALUResult=0, Zero=1, counter=0 and accumulator=0 immediately; in_ready SHALL be 1 and out_valid 0 while reset is high.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation with no output produced after release.

Structure
REQ-028 The operation-code localparams and the state enum SHALL live in the shared package alu_pkg, also imported by the ALU controller.
REQ-029 The single-step shifter SHALL be one combinational sub-module, alu_shift1 (input: value and mode; output: value shifted by 1).

Verification
REQ-030 The bench SHALL check ADD with SrcA=0xFFFFFFFF, SrcB=1 -> out_valid 1 cycle after accept, ALUResult=0, Zero=1.
REQ-031 The bench SHALL check SRA with SrcA=0x80000000, SrcB=4 -> out_valid 5 cycles after accept, ALUResult=0xF8000000, in_ready=0 for those cycles.
REQ-032 The bench SHALL check SLT with SrcA=0xFFFFFFFE (-2), SrcB=1 -> ALUResult=1; BGE with the same operands -> ALUResult=0, Zero=1.
REQ-033 The bench SHALL check backpressure: SLL with SrcA=1, SrcB=31, out_ready=0 for 10 cycles after DONE -> ALUResult=0x80000000 held stable, then 1 cycle to IDLE after out_ready=1.
REQ-034 The bench SHALL check flush on the 3rd SHIFT cycle of SRL with SrcB=20 -> IDLE next edge, out_valid never high, next ADD 2+3=5 correct.
REQ-035 The bench SHALL check reset asserted mid-SHIFT -> in_ready=1, out_valid=0, ALUResult=0 asynchronously; Operation 1111 -> ALUResult=0.
